count_sequence_monitor: RTL
===========================

# count_sequence_monitor

Observer for a mod-2^WIDTH up/down counter: the receiving end of the counter's output bus. Samples the counter value every rising CLOCK edge, predicts the next value from direction and hold inputs, locks onto a valid sequence and flags any deviation. Sits beside the counter in benches and on-chip self-check paths, and reports lock status, mismatches, wrap events and a saturating error tally.

## Interface
- WIDTH, 4: counter width; modulus is 2^WIDTH.
- LOCK_CYCLES, 2: consecutive correct transitions required to lock (≥1).
- ERR_CNT_W, 8: width of the error tally.
- CLOCK input 1: single clock, rising-edge active.
- CLEAR input 1: asynchronous, active-high reset.
- COUNT input WIDTH: observed counter value, stable at each rising CLOCK edge.
- MODE input 1: observed counter direction, 0 = up, 1 = down.
- HOLD input 1: 1 = observed counter is not expected to change on the next edge.
- LOCKED output 1: 1 while in TRACK.
- MISMATCH output 1: one-cycle pulse on a bad transition while locked.
- EXPECTED output WIDTH: value COUNT must take at the next edge.
- ERR_COUNT output ERR_CNT_W: saturating mismatch tally.
- WRAP output 1: one-cycle pulse on a correct wrap transition while locked.

## Operation
- Reset values: LOCKED=0, MISMATCH=0, EXPECTED=0, ERR_COUNT=0, WRAP=0, state=ACQ, lock counter=0, valid flag=0, registered mode/hold=0.
- At every edge, EXPECTED <= next(COUNT, MODE, HOLD): COUNT when HOLD=1, otherwise (COUNT+1) mod 2^WIDTH for up or (COUNT−1) mod 2^WIDTH for down. MODE and HOLD are registered alongside it for wrap classification.
- The match condition is COUNT == EXPECTED, evaluated at the edge against the EXPECTED value registered at the previous edge.
- State ACQ:
  - First edge after reset only captures: valid flag <= 1, no comparison.
  - On a match, the lock counter increments. On a miss, it clears. Neither case produces MISMATCH or ERR_COUNT activity.
  - When the lock counter reaches LOCK_CYCLES on an edge, the block enters TRACK and LOCKED=1 from that edge.
- State TRACK:
  - On a match, the block stays in TRACK.
  - On a miss, MISMATCH=1 for one cycle and ERR_COUNT increments, saturating at 2^ERR_CNT_W−1. State returns to ACQ, LOCKED=0 and the lock counter clears. EXPECTED resynchronises from the actual COUNT, so a relock needs only LOCK_CYCLES further correct edges.
- Simultaneous changes: MODE/HOLD sampled at edge k govern the k→k+1 transition only. A direction change takes effect one edge after it is sampled.
- CLEAR asserted at any time, including mid-TRACK or on a mismatch edge, forces all reset values immediately. ERR_COUNT is not preserved.

## Timing
- Zero-latency compare: MISMATCH, WRAP, LOCKED and ERR_COUNT update at the same edge that samples the offending or qualifying COUNT, and are visible for the following cycle.
- Lock latency from reset release is 1 + LOCK_CYCLES edges for a clean sequence.
- All outputs are registered; there is no combinational path from inputs to outputs.
- CLEAR deassertion is synchronous to the design by assumption of the environment. The first edge after release is the capture edge.

## Configuration
- COUNT_MON_WRAP_EN defined:
  - WRAP pulses on a TRACK match where the registered HOLD=0 and either registered MODE=0 with COUNT=0 (2^WIDTH−1→0), or registered MODE=1 with COUNT=2^WIDTH−1 (0→2^WIDTH−1).
  - WRAP never pulses in ACQ or on a mismatch.
- COUNT_MON_WRAP_EN undefined: WRAP is tied to 0 and the wrap-classification logic is not built. All other behaviour is identical.

## Test plan
- Reset, then MODE=0, HOLD=0, COUNT 0,1,…,15,0: LOCKED rises at edge 3; WRAP pulses (with COUNT_MON_WRAP_EN) at the 15→0 edge; MISMATCH never asserts; ERR_COUNT=0.
- MODE=1, COUNT 5,4,3,2,1,0,15: lock at the third edge; WRAP pulses at 0→15; EXPECTED=14 after the final edge.
- Locked up at COUNT=7, next COUNT=9: one-cycle MISMATCH, ERR_COUNT=1, LOCKED=0, EXPECTED=10; COUNT 10,11 relocks at the second edge.
- Locked, HOLD=1, COUNT=6 for 3 edges: no MISMATCH. Then COUNT=7 while registered HOLD=1: MISMATCH pulse and ERR_COUNT increments.
- ERR_CNT_W=2, five lock/mismatch cycles: ERR_COUNT goes 1,2,3,3,3.
- CLEAR pulsed mid-TRACK between edges with ERR_COUNT=2: all outputs read 0 before the next edge; the next edge is capture-only.

Source files
------------

// File: rtl/count_sequence_monitor.sv
// count_sequence_monitor
//   Observer for a mod-2^WIDTH up/down counter. The block samples the observed
//   count on every rising clock edge and predicts the value for the next edge
//   from the sampled direction and hold inputs. It locks after LOCK_CYCLES
//   consecutive correct transitions. Once locked, it flags a deviation, counts
//   errors in a saturating tally and, optionally, reports correct wrap-around
//   transitions.
//
//   Optional feature: define COUNT_MON_WRAP_EN to build the wrap classifier.
//   Without it, wrap is tied to 0.
//
// Parameters
//   WIDTH       : counter width (modulus 2^WIDTH)
//   LOCK_CYCLES : consecutive correct transitions needed to lock (>= 1)
//   ERR_CNT_W   : width of the saturating error tally
// Ports
//   clock     in  : rising-edge clock
//   clear     in  : asynchronous active-high reset
//   count     in  : observed counter value
//   mode      in  : observed direction, 0 = up, 1 = down
//   hold      in  : 1 = counter expected to stay put on the next edge
//   locked    out : 1 while tracking
//   mismatch  out : one-cycle pulse on a bad transition while locked
//   expected  out : value count must take at the next edge
//   err_count out : saturating mismatch tally
//   wrap      out : one-cycle pulse on a correct wrap while locked
module count_sequence_monitor #(
  parameter int WIDTH       = 4,
  parameter int LOCK_CYCLES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     count,
  input  logic                 mode,
  input  logic                 hold,
  output logic                 locked,
  output logic                 mismatch,
  output logic [WIDTH-1:0]     expected,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wrap
);

  typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

  localparam int                   LCW         = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0]       LOCK_TARGET = LCW'(LOCK_CYCLES);
  localparam logic [LCW-1:0]       ONE_L       = LCW'(1);
  localparam logic [WIDTH-1:0]     ONE_W       = WIDTH'(1);
  localparam logic [ERR_CNT_W-1:0] ONE_E       = ERR_CNT_W'(1);

  // Value the counter must show one edge after showing c.
  function automatic logic [WIDTH-1:0] predict(input logic [WIDTH-1:0] c,
                                               input logic m, input logic h);
    if (h)      return c;
    else if (m) return c - ONE_W;
    else        return c + ONE_W;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + ONE_E;
  endfunction

  state_t               state, state_nxt;
  logic                 valid, valid_nxt;
  logic [LCW-1:0]       lock_cnt, lock_cnt_nxt;
  logic                 mismatch_nxt;
  logic [ERR_CNT_W-1:0] err_nxt;
  logic [WIDTH-1:0]     expected_nxt;
  logic                 match;

  // Locked is a pure decode of the state flop, so it stays registered.
  assign locked = (state == TRACK);

  always_comb begin
    state_nxt    = state;
    valid_nxt    = 1'b1;
    lock_cnt_nxt = lock_cnt;
    mismatch_nxt = 1'b0;
    err_nxt      = err_count;
    // The prediction always follows the observed count. After a miss, it
    // therefore resynchronises to the real sequence without extra handling.
    expected_nxt = predict(count, mode, hold);
    match        = (count == expected);

    // The first edge after reset only captures. Nothing is compared on it.
    if (valid) begin
      case (state)
        ACQ: begin
          if (match) begin
            if (lock_cnt + ONE_L == LOCK_TARGET) begin
              state_nxt    = TRACK;
              lock_cnt_nxt = '0;
            end else begin
              lock_cnt_nxt = lock_cnt + ONE_L;
            end
          end else begin
            lock_cnt_nxt = '0;
          end
        end
        TRACK: begin
          if (!match) begin
            state_nxt    = ACQ;
            lock_cnt_nxt = '0;
            mismatch_nxt = 1'b1;
            err_nxt      = sat_inc(err_count);
          end
        end
        default: state_nxt = ACQ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= ACQ;
      valid     <= 1'b0;
      lock_cnt  <= '0;
      mismatch  <= 1'b0;
      err_count <= '0;
      expected  <= '0;
    end else begin
      state     <= state_nxt;
      valid     <= valid_nxt;
      lock_cnt  <= lock_cnt_nxt;
      mismatch  <= mismatch_nxt;
      err_count <= err_nxt;
      expected  <= expected_nxt;
    end
  end

`ifdef COUNT_MON_WRAP_EN
  // Direction and hold are registered with the prediction. A wrap is
  // classified against the transition those values governed.
  logic mode_r, hold_r, wrap_nxt;

  always_comb begin
    wrap_nxt = valid && (state == TRACK) && match && !hold_r &&
               ((!mode_r && (count == '0)) || (mode_r && (count == '1)));
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      mode_r <= 1'b0;
      hold_r <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      mode_r <= mode;
      hold_r <= hold;
      wrap   <= wrap_nxt;
    end
  end
`else
  assign wrap = 1'b0;
`endif

endmodule
